// File: rtl/axis_packet_buffer.sv
// axis_packet_buffer: single-clock AXI-Stream store-and-forward packet buffer.
// Beats from s01 land in a circular RAM; m01 only sees a packet once its tlast beat is stored.
// Build option: AXIS_PKT_BUF_DROP_EN drops packets that overflow the RAM and adds drop_pulse.
//
// Read FSM
//   state  | meaning
//   IDLE   | no committed packet pending, RAM reads parked
//   STREAM | committed packet(s) pending, RAM reads run ahead of m01 into the skid stage
module axis_packet_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_SIZE   = 4096,
  parameter int MAX_PKTS   = 16
) (
  input  logic                      s01_axis_aclk,
  input  logic                      s01_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]     s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s01_axis_tstrb,
  input  logic                      s01_axis_tvalid,
  input  logic                      s01_axis_tlast,
  output logic                      s01_axis_tready,
  input  logic                      m01_axis_tready,
  output logic [DATA_WIDTH-1:0]     m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m01_axis_tstrb,
  output logic                      m01_axis_tvalid,
  output logic                      m01_axis_tlast,
  output logic [$clog2(MAX_PKTS):0] pkt_count,
  output logic [ADDR_WIDTH:0]       free_words
`ifdef AXIS_PKT_BUF_DROP_EN
  ,
  output logic                      drop_pulse
`endif
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int WW  = DATA_WIDTH + SW + 1;
  localparam int PCW = $clog2(MAX_PKTS) + 1;
  localparam int CW  = ADDR_WIDTH + 1;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  logic [WW-1:0]         mem [MEM_SIZE];
  logic [WW-1:0]         ram_q;
  logic                  ram_q_valid;
  logic [WW-1:0]         stg0;
  logic [WW-1:0]         stg1;
  logic [1:0]            stg_cnt;
  logic [1:0]            stg_keep;

  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         cur_len, cur_len_next;
  logic [CW-1:0]         unread, unread_next;
  logic [CW-1:0]         free_next;
  logic [PCW-1:0]        pkt_next;
  logic                  ready_next;

  logic                  wr_hs, rd_hs, wr_store, commit, pkt_done, rd_issue;
  state_t                state, state_next;

`ifdef AXIS_PKT_BUF_DROP_EN
  logic [ADDR_WIDTH-1:0] commit_ptr;
  logic                  dropping, dropping_next;
  logic                  drop_beat, rollback;
`endif

  assign m01_axis_tvalid = (stg_cnt != 2'd0);
  assign {m01_axis_tlast, m01_axis_tstrb, m01_axis_tdata} = stg0;

  // Write-side bookkeeping: store/commit/drop decisions and the next counter values.
  always_comb begin
    wr_hs    = s01_axis_tvalid && s01_axis_tready;
    rd_hs    = m01_axis_tvalid && m01_axis_tready;
    pkt_done = rd_hs && m01_axis_tlast;
`ifdef AXIS_PKT_BUF_DROP_EN
    // A beat with no free slot kills the packet in flight; the rest of it is swallowed.
    drop_beat     = wr_hs && (dropping || (free_words == '0));
    rollback      = drop_beat && !dropping;
    wr_store      = wr_hs && !drop_beat;
    dropping_next = dropping;
    if (drop_beat) dropping_next = !s01_axis_tlast;
`else
    wr_store = wr_hs;
`endif
    commit = wr_store && s01_axis_tlast;

    wr_ptr_next = wr_ptr;
    if (wr_store) wr_ptr_next = wr_ptr + ADDR_WIDTH'(1);

    cur_len_next = cur_len;
    if (commit) cur_len_next = '0;
    else if (wr_store) cur_len_next = cur_len + CW'(1);

    free_next = free_words;
    if (rd_hs) free_next = free_next + CW'(1);
    if (wr_store) free_next = free_next - CW'(1);

`ifdef AXIS_PKT_BUF_DROP_EN
    if (rollback) begin
      wr_ptr_next  = commit_ptr;
      cur_len_next = '0;
      free_next    = free_next + cur_len;
    end
`endif

    pkt_next = pkt_count;
    if (commit && !pkt_done) pkt_next = pkt_count + PCW'(1);
    else if (!commit && pkt_done) pkt_next = pkt_count - PCW'(1);

    unread_next = unread;
    if (commit) unread_next = unread_next + cur_len + CW'(1);
    if (rd_issue) unread_next = unread_next - CW'(1);

`ifdef AXIS_PKT_BUF_DROP_EN
    // Mid-packet the port stays open even when full so an oversized packet can be drained and dropped.
    ready_next = ((free_next != '0) || (cur_len_next != '0) || dropping_next) &&
                 (pkt_next < PCW'(MAX_PKTS));
`else
    ready_next = (free_next != '0) && (pkt_next < PCW'(MAX_PKTS));
`endif
  end

  // Read FSM next state and RAM read issue; reads are credit-limited to the 2-entry skid stage.
  always_comb begin
    state_next = state;
    rd_issue   = 1'b0;
    stg_keep   = stg_cnt - {1'b0, rd_hs};
    case (state)
      IDLE: begin
        if (pkt_next != '0) state_next = STREAM;
      end
      STREAM: begin
        rd_issue = (unread != '0) && ((stg_keep + {1'b0, ram_q_valid}) < 2'd2);
        if (pkt_next == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Packet RAM: one write port from s01, one synchronous read port feeding the skid stage.
  always_ff @(posedge s01_axis_aclk) begin
    if (wr_store) mem[wr_ptr] <= {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};
    if (rd_issue) ram_q <= mem[rd_ptr];
  end

  // Pointers, counters, FSM state and registered tready.
  always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
    if (!s01_axis_aresetn) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cur_len         <= '0;
      unread          <= '0;
      free_words      <= CW'(MEM_SIZE);
      pkt_count       <= '0;
      s01_axis_tready <= 1'b0;
      ram_q_valid     <= 1'b0;
    end else begin
      state           <= state_next;
      wr_ptr          <= wr_ptr_next;
      cur_len         <= cur_len_next;
      unread          <= unread_next;
      free_words      <= free_next;
      pkt_count       <= pkt_next;
      s01_axis_tready <= ready_next;
      ram_q_valid     <= rd_issue;
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
    end
  end

  // Skid stage: head entry drives m01 and holds its value while empty.
  always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
    if (!s01_axis_aresetn) begin
      stg0    <= '0;
      stg1    <= '0;
      stg_cnt <= 2'd0;
    end else begin
      if (rd_hs && (stg_cnt == 2'd2)) stg0 <= stg1;
      if (ram_q_valid) begin
        if (stg_keep == 2'd0) stg0 <= ram_q;
        else stg1 <= ram_q;
      end
      stg_cnt <= stg_keep + {1'b0, ram_q_valid};
    end
  end

`ifdef AXIS_PKT_BUF_DROP_EN
  // Drop tracking: packet start pointer for rollback and the one-cycle drop indication.
  always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
    if (!s01_axis_aresetn) begin
      commit_ptr <= '0;
      dropping   <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      if (commit) commit_ptr <= wr_ptr + ADDR_WIDTH'(1);
      dropping   <= dropping_next;
      drop_pulse <= drop_beat && s01_axis_tlast;
    end
  end
`endif

endmodule

// File: tb/tb_axis_packet_buffer.sv
// Directed bench for axis_packet_buffer: a 4096-deep instance and a 16-deep instance.
module tb_axis_packet_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // large instance
  logic [31:0] bs_data = '0;
  logic [3:0]  bs_strb = '0;
  logic        bs_valid = 1'b0, bs_last = 1'b0, bs_ready;
  logic        bm_ready = 1'b0;
  logic [31:0] bm_data;
  logic [3:0]  bm_strb;
  logic        bm_valid, bm_last;
  logic [4:0]  b_pkt;
  logic [12:0] b_free;

  // small instance
  logic [31:0] ss_data = '0;
  logic [3:0]  ss_strb = '0;
  logic        ss_valid = 1'b0, ss_last = 1'b0, ss_ready;
  logic        sm_ready = 1'b0;
  logic [31:0] sm_data;
  logic [3:0]  sm_strb;
  logic        sm_valid, sm_last;
  logic [4:0]  s_pkt;
  logic [4:0]  s_free;
`ifdef AXIS_PKT_BUF_DROP_EN
  logic        b_drop, s_drop;
`endif

  int total = 0;
  int bad = 0;
  int drop_seen = 0;
  logic [36:0] sm_out_q[$];

  axis_packet_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .MEM_SIZE(4096), .MAX_PKTS(16)) dut_big (
    .s01_axis_aclk(clk), .s01_axis_aresetn(rst_n),
    .s01_axis_tdata(bs_data), .s01_axis_tstrb(bs_strb), .s01_axis_tvalid(bs_valid),
    .s01_axis_tlast(bs_last), .s01_axis_tready(bs_ready),
    .m01_axis_tready(bm_ready), .m01_axis_tdata(bm_data), .m01_axis_tstrb(bm_strb),
    .m01_axis_tvalid(bm_valid), .m01_axis_tlast(bm_last),
    .pkt_count(b_pkt), .free_words(b_free)
`ifdef AXIS_PKT_BUF_DROP_EN
    , .drop_pulse(b_drop)
`endif
  );

  axis_packet_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_SIZE(16), .MAX_PKTS(16)) dut_small (
    .s01_axis_aclk(clk), .s01_axis_aresetn(rst_n),
    .s01_axis_tdata(ss_data), .s01_axis_tstrb(ss_strb), .s01_axis_tvalid(ss_valid),
    .s01_axis_tlast(ss_last), .s01_axis_tready(ss_ready),
    .m01_axis_tready(sm_ready), .m01_axis_tdata(sm_data), .m01_axis_tstrb(sm_strb),
    .m01_axis_tvalid(sm_valid), .m01_axis_tlast(sm_last),
    .pkt_count(s_pkt), .free_words(s_free)
`ifdef AXIS_PKT_BUF_DROP_EN
    , .drop_pulse(s_drop)
`endif
  );

  // one clock: record small-instance output handshakes, then step to 1ns past the edge
  task automatic cyc();
    if (sm_valid && sm_ready) sm_out_q.push_back({sm_last, sm_strb, sm_data});
    @(posedge clk);
    #1;
`ifdef AXIS_PKT_BUF_DROP_EN
    if (s_drop) drop_seen++;
`endif
  endtask

  task automatic big_send(input logic [31:0] d, input logic [3:0] st, input logic l);
    int n;
    logic hs;
    n = 0;
    hs = 1'b0;
    bs_data = d; bs_strb = st; bs_last = l; bs_valid = 1'b1;
    while (!hs && n < 200) begin
      hs = bs_ready;
      cyc();
      n++;
    end
    bs_valid = 1'b0;
    if (!hs) begin
      total++; bad++;
      $display("FAIL big_send_timeout data=%h got=no_handshake need=handshake", d);
    end
  endtask

  task automatic small_send(input logic [31:0] d, input logic [3:0] st, input logic l);
    int n;
    logic hs;
    n = 0;
    hs = 1'b0;
    ss_data = d; ss_strb = st; ss_last = l; ss_valid = 1'b1;
    while (!hs && n < 200) begin
      hs = ss_ready;
      cyc();
      n++;
    end
    ss_valid = 1'b0;
    if (!hs) begin
      total++; bad++;
      $display("FAIL small_send_timeout data=%h got=no_handshake need=handshake", d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    total++; if (bm_valid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%0b need=0", bm_valid); end
    total++; if (bm_data !== 32'h0) begin bad++; $display("FAIL rst_tdata got=%h need=0", bm_data); end
    total++; if (bs_ready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%0b need=0", bs_ready); end
    total++; if (b_pkt !== 5'd0) begin bad++; $display("FAIL rst_pkt got=%0d need=0", b_pkt); end
    total++; if (b_free !== 13'd4096) begin bad++; $display("FAIL rst_free got=%0d need=4096", b_free); end
    total++; if (s_free !== 5'd16) begin bad++; $display("FAIL rst_free_small got=%0d need=16", s_free); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    total++; if (bs_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b need=1", bs_ready); end
  endtask

  task automatic test_basic();
    bm_ready = 1'b1;
    for (int i = 0; i < 4; i++) big_send(32'h10 + i, 4'hF, i == 3);
    total++; if (b_pkt !== 5'd1) begin bad++; $display("FAIL basic_pkt_commit got=%0d need=1", b_pkt); end
    total++; if (b_free !== 13'd4092) begin bad++; $display("FAIL basic_free got=%0d need=4092", b_free); end
    total++; if (bm_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_n0 got=%0b need=0", bm_valid); end
    cyc();
    total++; if (bm_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_n1 got=%0b need=0", bm_valid); end
    cyc();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({bm_valid, bm_last, bm_strb, bm_data} !== {1'b1, (i == 3), 4'hF, 32'h10 + i}) begin
        bad++;
        $display("FAIL basic_beat%0d got=v%0b l%0b s%h d%h need=v1 l%0b sF d%h",
                 i, bm_valid, bm_last, bm_strb, bm_data, (i == 3), 32'h10 + i);
      end
      cyc();
    end
    total++; if (b_pkt !== 5'd0) begin bad++; $display("FAIL basic_pkt_drain got=%0d need=0", b_pkt); end
    total++; if (b_free !== 13'd4096) begin bad++; $display("FAIL basic_free_drain got=%0d need=4096", b_free); end
    total++; if (bm_valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%0b need=0", bm_valid); end
  endtask

  task automatic test_pkt_limit();
    int got;
    int n;
    bm_ready = 1'b0;
    for (int i = 0; i < 16; i++) big_send(32'hA0 + i, 4'h5, 1'b1);
    total++; if (b_pkt !== 5'd16) begin bad++; $display("FAIL limit_pkt got=%0d need=16", b_pkt); end
    total++; if (bs_ready !== 1'b0) begin bad++; $display("FAIL limit_ready got=%0b need=0", bs_ready); end
    total++; if (b_free !== 13'd4080) begin bad++; $display("FAIL limit_free got=%0d need=4080", b_free); end
    repeat (3) cyc();
    total++; if (bs_ready !== 1'b0) begin bad++; $display("FAIL limit_ready_hold got=%0b need=0", bs_ready); end
    total++; if ({bm_valid, bm_data} !== {1'b1, 32'hA0}) begin bad++; $display("FAIL limit_head got=v%0b d%h need=v1 dA0", bm_valid, bm_data); end
    bm_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 16 && n < 100) begin
      if (bm_valid) begin
        total++;
        if ({bm_last, bm_strb, bm_data} !== {1'b1, 4'h5, 32'hA0 + got}) begin
          bad++;
          $display("FAIL limit_beat%0d got=l%0b s%h d%h need=l1 s5 d%h", got, bm_last, bm_strb, bm_data, 32'hA0 + got);
        end
        got++;
      end
      cyc();
      n++;
    end
    total++; if (got != 16) begin bad++; $display("FAIL limit_count got=%0d need=16", got); end
    total++; if (b_pkt !== 5'd0) begin bad++; $display("FAIL limit_pkt_drain got=%0d need=0", b_pkt); end
    total++; if (b_free !== 13'd4096) begin bad++; $display("FAIL limit_free_drain got=%0d need=4096", b_free); end
  endtask

  task automatic test_full_backpressure();
    logic [36:0] exp [17];
    sm_ready = 1'b0;
    sm_out_q.delete();
    for (int i = 0; i < 4; i++) small_send(32'h30 + i, 4'hF, i == 3);
    for (int i = 0; i < 12; i++) small_send(32'h40 + i, 4'h3, 1'b0);
    total++; if (s_free !== 5'd0) begin bad++; $display("FAIL full_free got=%0d need=0", s_free); end
    total++; if (ss_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b need=0", ss_ready); end
    repeat (3) cyc();
    total++; if (ss_ready !== 1'b0) begin bad++; $display("FAIL full_ready_hold got=%0b need=0", ss_ready); end
    sm_ready = 1'b1;
    cyc();
    sm_ready = 1'b0;
    total++; if (s_free !== 5'd1) begin bad++; $display("FAIL full_free_after_read got=%0d need=1", s_free); end
    total++; if (ss_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_read got=%0b need=1", ss_ready); end
    small_send(32'h4C, 4'h3, 1'b1);
    sm_ready = 1'b1;
    repeat (60) cyc();
    sm_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp[i] = {(i == 3), 4'hF, 32'h30 + i};
    for (int i = 4; i < 17; i++) exp[i] = {(i == 16), 4'h3, 32'h40 + (i - 4)};
    total++; if (sm_out_q.size() != 17) begin bad++; $display("FAIL full_out_count got=%0d need=17", sm_out_q.size()); end
    for (int i = 0; i < 17 && i < sm_out_q.size(); i++) begin
      total++;
      if (sm_out_q[i] !== exp[i]) begin bad++; $display("FAIL full_out%0d got=%h need=%h", i, sm_out_q[i], exp[i]); end
    end
    total++; if (s_free !== 5'd16) begin bad++; $display("FAIL full_free_drain got=%0d need=16", s_free); end
  endtask

  task automatic test_random();
    logic [36:0] src[$];
    logic [36:0] exp_q[$];
    logic [36:0] cur, prev_word, want;
    logic prev_stall, s_hs;
    int idx, n, len;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(1, 64);
      for (int b = 0; b < len; b++) begin
        cur = {(b == len - 1), 4'($urandom_range(0, 15)), 32'($urandom)};
        src.push_back(cur);
        exp_q.push_back(cur);
      end
    end
    idx = 0;
    n = 0;
    prev_stall = 1'b0;
    prev_word = '0;
    bs_valid = 1'b0;
    bm_ready = 1'b0;
    while (exp_q.size() > 0 && n < 40000) begin
      cur = {bm_last, bm_strb, bm_data};
      if (prev_stall) begin
        total++;
        if (bm_valid !== 1'b1 || cur !== prev_word) begin
          bad++;
          $display("FAIL rand_stable got=v%0b %h need=v1 %h", bm_valid, cur, prev_word);
        end
      end
      if (bm_valid && bm_ready) begin
        want = exp_q.pop_front();
        total++;
        if (cur !== want) begin bad++; $display("FAIL rand_beat got=%h need=%h", cur, want); end
      end
      prev_stall = bm_valid && !bm_ready;
      prev_word = cur;
      s_hs = bs_valid && bs_ready;
      cyc();
      n++;
      if (s_hs) idx++;
      if (!bs_valid || s_hs) begin
        if (idx < src.size() && $urandom_range(0, 3) != 0) begin
          {bs_last, bs_strb, bs_data} = src[idx];
          bs_valid = 1'b1;
        end else begin
          bs_valid = 1'b0;
        end
      end
      bm_ready = ($urandom_range(0, 3) != 0);
    end
    bs_valid = 1'b0;
    bm_ready = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_remaining got=%0d need=0", exp_q.size()); end
    repeat (3) cyc();
    total++; if (b_free !== 13'd4096) begin bad++; $display("FAIL rand_free got=%0d need=4096", b_free); end
    total++; if (b_pkt !== 5'd0) begin bad++; $display("FAIL rand_pkt got=%0d need=0", b_pkt); end
  endtask

  task automatic test_reset_mid_packet();
    int got;
    bm_ready = 1'b0;
    for (int i = 0; i < 4; i++) big_send(32'h50 + i, 4'hF, i == 3);
    repeat (3) cyc();
    bm_ready = 1'b1;
    cyc();
    bm_ready = 1'b0;
    big_send(32'h60, 4'hF, 1'b0);
    big_send(32'h61, 4'hF, 1'b0);
    bs_data = 32'h62; bs_strb = 4'hF; bs_last = 1'b0; bs_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bm_valid, bm_last, bm_strb, bm_data, bs_ready} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs got=v%0b l%0b s%h d%h r%0b need=all0", bm_valid, bm_last, bm_strb, bm_data, bs_ready);
    end
    total++; if (b_free !== 13'd4096) begin bad++; $display("FAIL midrst_free got=%0d need=4096", b_free); end
    total++; if (b_pkt !== 5'd0) begin bad++; $display("FAIL midrst_pkt got=%0d need=0", b_pkt); end
    cyc();
    bs_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bm_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      if (bm_valid) got++;
      cyc();
    end
    total++; if (got != 0) begin bad++; $display("FAIL midrst_stale_beats got=%0d need=0", got); end
    for (int i = 0; i < 3; i++) big_send(32'h70 + i, 4'h9, i == 2);
    got = 0;
    for (int n = 0; n < 20; n++) begin
      if (bm_valid) begin
        total++;
        if ({bm_last, bm_strb, bm_data} !== {(got == 2), 4'h9, 32'h70 + got}) begin
          bad++;
          $display("FAIL midrst_beat%0d got=l%0b s%h d%h need=l%0b s9 d%h", got, bm_last, bm_strb, bm_data, (got == 2), 32'h70 + got);
        end
        got++;
      end
      cyc();
    end
    total++; if (got != 3) begin bad++; $display("FAIL midrst_count got=%0d need=3", got); end
    total++; if (b_free !== 13'd4096) begin bad++; $display("FAIL midrst_free_end got=%0d need=4096", b_free); end
    bm_ready = 1'b0;
  endtask

`ifdef AXIS_PKT_BUF_DROP_EN
  task automatic test_drop();
    sm_ready = 1'b1;
    sm_out_q.delete();
    drop_seen = 0;
    for (int i = 0; i < 20; i++) small_send(32'h80 + i, 4'hF, i == 19);
    total++; if (s_drop !== 1'b1) begin bad++; $display("FAIL drop_pulse_on_tlast got=%0b need=1", s_drop); end
    total++; if (s_free !== 5'd16) begin bad++; $display("FAIL drop_free_restored got=%0d need=16", s_free); end
    small_send(32'h90, 4'h1, 1'b0);
    small_send(32'h91, 4'h2, 1'b1);
    repeat (20) cyc();
    total++; if (drop_seen != 1) begin bad++; $display("FAIL drop_pulse_count got=%0d need=1", drop_seen); end
    total++; if (sm_out_q.size() != 2) begin bad++; $display("FAIL drop_out_count got=%0d need=2", sm_out_q.size()); end
    if (sm_out_q.size() >= 2) begin
      total++; if (sm_out_q[0] !== {1'b0, 4'h1, 32'h90}) begin bad++; $display("FAIL drop_out0 got=%h need=%h", sm_out_q[0], {1'b0, 4'h1, 32'h90}); end
      total++; if (sm_out_q[1] !== {1'b1, 4'h2, 32'h91}) begin bad++; $display("FAIL drop_out1 got=%h need=%h", sm_out_q[1], {1'b1, 4'h2, 32'h91}); end
    end
    total++; if (s_free !== 5'd16) begin bad++; $display("FAIL drop_free_end got=%0d need=16", s_free); end
    sm_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_pkt_limit();
    test_full_backpressure();
    test_random();
    test_reset_mid_packet();
`ifdef AXIS_PKT_BUF_DROP_EN
    test_drop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
